program_counter_stack: RTL

//  Parametrised program counter with hardware call/return stack and stall.

---
 rtl/program_counter_stack.sv | 107 ++++++++++
 1 files changed

// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch-stage PC with a hardware return-address stack.
// Supports increment, absolute load, signed relative branch, call and return,
// plus a sticky fault flag for stack overflow and underflow.
// Ports:
//   i_Clock, i_Reset       rising-edge clock, synchronous active-high reset
//   i_Stall                hold PC and stack for this cycle
//   i_LoadEnable/Value     absolute jump; i_LoadValue is also the call target
//   i_OffsetEnable/Offset  signed relative branch
//   i_CallEnable           push PC+1 and jump to i_LoadValue
//   i_ReturnEnable         pop the top entry into the PC
//   o_CounterValue         current PC (instruction-memory address)
//   o_StackCount           number of valid return addresses
//   o_Fault                sticky overflow/underflow error, cleared by reset
module program_counter_stack #(
   parameter int                WIDTH        = 16,
   parameter int                OFFSET_WIDTH = 9,
   parameter int                STACK_DEPTH  = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE  = '0
) (
   input  logic                                 i_Clock,
   input  logic                                 i_Reset,
   input  logic                                 i_Stall,
   input  logic                                 i_LoadEnable,
   input  logic [WIDTH-1:0]                     i_LoadValue,
   input  logic                                 i_OffsetEnable,
   input  logic signed [OFFSET_WIDTH-1:0]       i_Offset,
   input  logic                                 i_CallEnable,
   input  logic                                 i_ReturnEnable,
   output logic signed [WIDTH-1:0]              o_CounterValue,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     o_StackCount,
   output logic                                 o_Fault
);

   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [WIDTH-1:0] r_pc;
   logic [CW-1:0]    r_count;
   logic             r_fault;
   logic [WIDTH-1:0] r_stack [0:STACK_DEPTH-1];

   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_off_ext;
   logic [CW-1:0]    w_count_dec;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_active;
   logic             w_empty;
   logic             w_full;
   logic             w_push;

   assign w_pc_inc    = r_pc + WIDTH'(1);
   assign w_off_ext   = {{(WIDTH-OFFSET_WIDTH){i_Offset[OFFSET_WIDTH-1]}},
                         i_Offset};
   assign w_count_dec = r_count - CW'(1);
   // The count doubles as the push slot; the pop slot is one below it.
   assign w_wr_idx    = r_count[AW-1:0];
   assign w_rd_idx    = w_count_dec[AW-1:0];
   assign w_active    = !i_Reset && !r_fault && !i_Stall;
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CW'(STACK_DEPTH));
   // A call only pushes when no return outranks it and there is room.
   assign w_push      = w_active && !i_ReturnEnable &&
                        i_CallEnable && !w_full;

   // Storage is not reset; entries above the count are never read.
   always_ff @(posedge i_Clock) begin
      if (w_push) begin
         r_stack[w_wr_idx] <= w_pc_inc;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_pc    <= RESET_VALUE;
         r_count <= '0;
         r_fault <= 1'b0;
      end else if (w_active) begin
         if (i_ReturnEnable) begin
            if (w_empty) begin
               r_fault <= 1'b1;
            end else begin
               r_pc    <= r_stack[w_rd_idx];
               r_count <= w_count_dec;
            end
         end else if (i_CallEnable) begin
            if (w_full) begin
               r_fault <= 1'b1;
            end else begin
               r_pc    <= i_LoadValue;
               r_count <= r_count + CW'(1);
            end
         end else if (i_LoadEnable) begin
            r_pc <= i_LoadValue;
         end else if (i_OffsetEnable) begin
            r_pc <= r_pc + w_off_ext;
         end else begin
            r_pc <= w_pc_inc;
         end
      end
   end

   assign o_CounterValue = r_pc;
   assign o_StackCount   = r_count;
   assign o_Fault        = r_fault;

endmodule
